// File: rtl/path_sift_down_engine.sv
// ---------------------------------------------------------------------------
// path_sift_down_engine
//
// Holds a heap array internally and restores the heap property below one node
// by walking the entry down the tree ("sift-down"). The heap can be a max-heap
// or a min-heap, binary or 4-ary. Each level of the walk takes one compare
// cycle and, if the entry has to move, one swap cycle.
//
// Ports
//   system1000      clock, all state changes on the rising edge
//   system1000_rst  asynchronous active-high reset (heap storage is kept)
//   wr_en/wr_idx/wr_data  write one heap slot while idle
//   rd_idx/rd_data        combinational read port, 0 outside the array
//   start/start_idx/heap_size  launch a sift of start_idx within heap_size
//   busy       high while an operation is in progress
//   done       one-cycle completion pulse
//   final_idx  resting place of the sifted entry, held until the next result
//   swap_cnt   number of swaps done by the last operation
// ---------------------------------------------------------------------------
module path_sift_down_engine #(
   parameter int KEY_W    = 32,
   parameter int ENTRY_W  = 65,
   parameter int DEPTH    = 1000,
   parameter int IDX_W    = 16,
   parameter int ARITY    = 2,
   parameter int MIN_HEAP = 0
) (
   input  logic               system1000,
   input  logic               system1000_rst,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [ENTRY_W-1:0] rd_data,
   input  logic               start,
   input  logic [IDX_W-1:0]   start_idx,
   input  logic [IDX_W-1:0]   heap_size,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   final_idx,
   output logic [IDX_W-1:0]   swap_cnt
);

   // Address width of the storage array.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Child indices are computed a few bits wider than IDX_W so that a large
   // cur never wraps around into a small, apparently valid child index.
   localparam int CW = IDX_W + 3;
   // ARITY is 2 or 4, so ARITY*cur is a plain shift.
   localparam int SHIFT = (ARITY == 4) ? 2 : 1;
   localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      SWAP,
      FIN
   } state_t;

   state_t state;
   state_t state_next;

   logic [ENTRY_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0] cur;
   logic [IDX_W-1:0] heap_lim;
   logic [IDX_W-1:0] child;
   logic [IDX_W-1:0] final_q;
   logic [IDX_W-1:0] swap_q;

   logic             write_ok;
   logic [CW-1:0]    child_base;
   logic [CW-1:0]    cand;
   logic [KEY_W-1:0] cand_key;
   logic             best_valid;
   logic [IDX_W-1:0] best_idx;
   logic [KEY_W-1:0] best_key;
   logic [KEY_W-1:0] parent_key;
   logic             cur_live;
   logic             do_swap;

   // "a is strictly better than b" for the configured heap flavour. Equal keys
   // are never better, which gives both the no-swap-on-tie rule and the
   // lowest-index tie break among children.
   function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
      if (MIN_HEAP != 0) begin
         return a < b;
      end
      return a > b;
   endfunction

   // Slot writes are only taken while idle and only for slots that exist;
   // anything else is dropped without side effects.
   assign write_ok = wr_en && (state == IDLE) && (wr_idx < DEPTH_I);

   assign rd_data = (rd_idx < DEPTH_I) ? mem[rd_idx[AW-1:0]] : '0;

   // Scan the children of cur in ascending index order and keep the best one.
   // Children at or beyond the live heap size are ignored; a later child only
   // replaces the current best if it is strictly better, so ties resolve to
   // the lowest index.
   always_comb begin
      child_base = {3'b000, cur} << SHIFT;
      cand       = '0;
      cand_key   = '0;
      best_valid = 1'b0;
      best_idx   = '0;
      best_key   = '0;
      for (int j = 1; j <= ARITY; j++) begin
         cand = child_base + CW'(j);
         if (cand < {3'b000, heap_lim}) begin
            cand_key = mem[cand[AW-1:0]][ENTRY_W-1 -: KEY_W];
            if (!best_valid || better(cand_key, best_key)) begin
               best_valid = 1'b1;
               best_idx   = cand[IDX_W-1:0];
               best_key   = cand_key;
            end
         end
      end
   end

   // The parent key only matters while cur is inside the live heap, which
   // also keeps the truncated storage address in range whenever it is used.
   assign cur_live   = cur < heap_lim;
   assign parent_key = mem[cur[AW-1:0]][ENTRY_W-1 -: KEY_W];
   assign do_swap    = cur_live && best_valid && better(best_key, parent_key);

   // State register; reset aborts any operation immediately.
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one compare per level, a swap cycle only when the
   // entry actually has to move down, and a single completion cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = CMP;
            end
         end
         CMP: begin
            if (do_swap) begin
               state_next = SWAP;
            end else begin
               state_next = FIN;
            end
         end
         SWAP: begin
            state_next = CMP;
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs are decoded straight from the state so that busy drops
   // in the same instant the reset forces IDLE.
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == FIN);
      final_idx = final_q;
      swap_cnt  = swap_q;
   end

   // Operation registers. The heap size is clamped to the storage depth on
   // start so children past the end of the array are never considered.
   // final_q is loaded on the way into FIN so it is already valid while done
   // is high, and then simply held.
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         cur      <= '0;
         heap_lim <= '0;
         child    <= '0;
         final_q  <= '0;
         swap_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cur      <= start_idx;
                  heap_lim <= (heap_size < DEPTH_I) ? heap_size : DEPTH_I;
                  swap_q   <= '0;
               end
            end
            CMP: begin
               if (do_swap) begin
                  child <= best_idx;
               end else begin
                  final_q <= cur;
               end
            end
            SWAP: begin
               cur    <= child;
               swap_q <= swap_q + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Heap storage has no reset so that an interrupted sift leaves every swap
   // that already completed in place. A swap exchanges whole entries, so the
   // payload always travels with its key. A slot write on the same edge as
   // start lands before the first compare, so the sift sees the new value.
   always_ff @(posedge system1000) begin
      if (state == SWAP) begin
         mem[cur[AW-1:0]]   <= mem[child[AW-1:0]];
         mem[child[AW-1:0]] <= mem[cur[AW-1:0]];
      end else if (write_ok) begin
         mem[wr_idx[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_path_sift_down_engine.sv
// ---------------------------------------------------------------------------
// tb_path_sift_down_engine
//
// Drives two engine instances: instance a is a binary max-heap, instance b is
// a 4-ary min-heap. Both share the stimulus wires, and sel chooses which one
// sees writes/start and whose outputs are observed. Expected results of each
// sift are queued when the start is driven and compared when done appears.
// ---------------------------------------------------------------------------
module tb_path_sift_down_engine;

   localparam int KEY_W   = 32;
   localparam int ENTRY_W = 65;
   localparam int DEPTH   = 32;
   localparam int IDX_W   = 16;

   typedef logic [ENTRY_W-1:0] entry_t;

   typedef struct {
      int fin;
      int sw;
      int lat;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               sel;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   entry_t             wr_data;
   logic [IDX_W-1:0]   rd_idx;
   logic               start;
   logic [IDX_W-1:0]   start_idx;
   logic [IDX_W-1:0]   heap_size;

   entry_t             rd_data_a, rd_data_b, rd_data;
   logic               busy_a, busy_b, busy;
   logic               done_a, done_b, done;
   logic [IDX_W-1:0]   final_idx_a, final_idx_b, final_idx;
   logic [IDX_W-1:0]   swap_cnt_a, swap_cnt_b, swap_cnt;

   logic               wr_en_a, wr_en_b, start_a, start_b;

   int                 checks;
   int                 errors;
   exp_t               sb[$];
   entry_t             ref_m[2][DEPTH];
   entry_t             orig[8];

   assign wr_en_a   = wr_en & ~sel;
   assign wr_en_b   = wr_en & sel;
   assign start_a   = start & ~sel;
   assign start_b   = start & sel;
   assign rd_data   = sel ? rd_data_b : rd_data_a;
   assign busy      = sel ? busy_b : busy_a;
   assign done      = sel ? done_b : done_a;
   assign final_idx = sel ? final_idx_b : final_idx_a;
   assign swap_cnt  = sel ? swap_cnt_b : swap_cnt_a;

   path_sift_down_engine #(
      .KEY_W(KEY_W), .ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
      .ARITY(2), .MIN_HEAP(0)
   ) dut_a (
      .system1000(clk), .system1000_rst(rst),
      .wr_en(wr_en_a), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_idx(rd_idx), .rd_data(rd_data_a),
      .start(start_a), .start_idx(start_idx), .heap_size(heap_size),
      .busy(busy_a), .done(done_a), .final_idx(final_idx_a), .swap_cnt(swap_cnt_a)
   );

   path_sift_down_engine #(
      .KEY_W(KEY_W), .ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
      .ARITY(4), .MIN_HEAP(1)
   ) dut_b (
      .system1000(clk), .system1000_rst(rst),
      .wr_en(wr_en_b), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_idx(rd_idx), .rd_data(rd_data_b),
      .start(start_b), .start_idx(start_idx), .heap_size(heap_size),
      .busy(busy_b), .done(done_b), .final_idx(final_idx_b), .swap_cnt(swap_cnt_b)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic entry_t mk(input int key, input int pay);
      return {32'(key), 33'(pay)};
   endfunction

   // Writes one slot of the selected instance and mirrors it in the
   // reference array when the slot exists.
   task automatic writeSlot(input int idx, input entry_t data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_idx  = IDX_W'(idx);
      wr_data = data;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (idx < DEPTH) ref_m[sel][idx] = data;
   endtask

   task automatic fillAll(input bit rnd);
      for (int i = 0; i < DEPTH; i++) begin
         if (rnd) writeSlot(i, {32'($urandom_range(0, 7)), 1'b0, $urandom()});
         else     writeSlot(i, mk(0, i));
      end
   endtask

   task automatic loadKeys(input int n, input int k0, input int k1, input int k2,
                           input int k3, input int k4, input int pay);
      int keys[5];
      keys = '{k0, k1, k2, k3, k4};
      for (int i = 0; i < n; i++) begin
         orig[i] = mk(keys[i], pay + i);
         writeSlot(i, orig[i]);
      end
   endtask

   task automatic checkArray(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         rd_idx = IDX_W'(i);
         #1;
         checkOutput($sformatf("%s[%0d]", tag, i), rd_data, ref_m[sel][i]);
      end
   endtask

   task automatic swapRef(input int a, input int b);
      entry_t t;
      t = ref_m[sel][a];
      ref_m[sel][a] = ref_m[sel][b];
      ref_m[sel][b] = t;
   endtask

   function automatic bit keyBetter(input int a, input int b);
      logic [KEY_W-1:0] ka, kb;
      ka = ref_m[sel][a][ENTRY_W-1 -: KEY_W];
      kb = ref_m[sel][b][ENTRY_W-1 -: KEY_W];
      return sel ? (ka < kb) : (ka > kb);
   endfunction

   // Reference sift-down on the bench copy of the selected heap.
   task automatic modelSift(input int sidx, input int hs, output int fin, output int sw);
      int ar, lim, cur, best, c;
      ar  = sel ? 4 : 2;
      lim = (hs < DEPTH) ? hs : DEPTH;
      cur = sidx;
      sw  = 0;
      for (int step = 0; step < 64; step++) begin
         if (cur >= lim) break;
         best = -1;
         for (int j = 1; j <= ar; j++) begin
            c = ar * cur + j;
            if (c < lim && (best < 0 || keyBetter(c, best))) best = c;
         end
         if (best >= 0 && keyBetter(best, cur)) begin
            swapRef(cur, best);
            cur = best;
            sw++;
         end else begin
            break;
         end
      end
      fin = cur;
   endtask

   // Queues the expected result, launches a sift (optionally with a slot
   // write on the same edge, optionally with ignored start/write pulses while
   // busy), waits for done within a bound and checks the popped result.
   task automatic applyStimulus(input int sidx, input int hs, input int efin, input int esw,
                                input int elat, input bit disturb, input bit wr_with,
                                input int wr_slot, input entry_t wr_val);
      int   edges;
      exp_t e;
      sb.push_back('{efin, esw, elat});
      @(negedge clk);
      start     = 1'b1;
      start_idx = IDX_W'(sidx);
      heap_size = IDX_W'(hs);
      if (wr_with) begin
         wr_en   = 1'b1;
         wr_idx  = IDX_W'(wr_slot);
         wr_data = wr_val;
         if (wr_slot < DEPTH) ref_m[sel][wr_slot] = wr_val;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      edges = 1;
      while (done !== 1'b1 && edges < 300) begin
         if (disturb && edges <= 3) begin
            start     = 1'b1;
            start_idx = 16'd1;
            heap_size = 16'd2;
            wr_en     = 1'b1;
            wr_idx    = 16'd0;
            wr_data   = '1;
         end else begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      wr_en = 1'b0;
      e = sb.pop_front();
      if (done !== 1'b1) begin
         checkOutput("done_timeout", done, 1);
         return;
      end
      checkOutput("done_latency", edges, e.lat);
      checkOutput("final_idx", final_idx, e.fin);
      checkOutput("swap_cnt", swap_cnt, e.sw);
      checkOutput("busy_at_done", busy, 1);
      @(posedge clk);
      #1;
      checkOutput("busy_after", busy, 0);
      checkOutput("done_after", done, 0);
      checkOutput("final_held", final_idx, e.fin);
      checkOutput("swap_held", swap_cnt, e.sw);
   endtask

   initial begin
      int     fin, sw, hs, sidx;
      entry_t nv;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      sel       = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = '0;
      wr_data   = '0;
      rd_idx    = '0;
      start     = 1'b0;
      start_idx = '0;
      heap_size = '0;

      // Reset values of both instances.
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_done", done, 0);
         checkOutput("rst_final", final_idx, 0);
         checkOutput("rst_swap", swap_cnt, 0);
      end
      @(negedge clk);
      rst = 1'b0;

      sel = 1'b1;
      fillAll(0);
      sel = 1'b0;
      fillAll(0);

      // Binary max-heap, two swaps down to slot 3.
      $display("[TB] max-heap two-swap vector");
      loadKeys(5, 1, 9, 5, 7, 3, 'h100);
      applyStimulus(0, 5, 3, 2, 6, 0, 0, 0, '0);
      ref_m[0][0] = orig[1]; ref_m[0][1] = orig[3]; ref_m[0][2] = orig[2];
      ref_m[0][3] = orig[0]; ref_m[0][4] = orig[4];
      checkArray("a037", 8);

      // All keys equal: no swap.
      $display("[TB] equal keys");
      loadKeys(3, 4, 4, 4, 0, 0, 'h200);
      applyStimulus(0, 3, 0, 0, 2, 0, 0, 0, '0);
      checkArray("a039", 8);

      // start_idx beyond heap_size.
      $display("[TB] start outside heap");
      loadKeys(5, 1, 9, 5, 7, 3, 'h300);
      applyStimulus(7, 5, 7, 0, 2, 0, 0, 0, '0);
      checkArray("a040", 16);

      // Start and write pulses while busy must be ignored.
      $display("[TB] pulses while busy");
      applyStimulus(0, 5, 3, 2, 6, 1, 0, 0, '0);
      ref_m[0][0] = orig[1]; ref_m[0][1] = orig[3]; ref_m[0][2] = orig[2];
      ref_m[0][3] = orig[0]; ref_m[0][4] = orig[4];
      checkArray("a042", 8);

      // Write and start on the same edge: the sift sees the new root.
      $display("[TB] write with start");
      loadKeys(3, 5, 3, 4, 0, 0, 'h400);
      nv = mk(1, 'h4ff);
      applyStimulus(0, 3, 2, 1, 4, 0, 1, 0, nv);
      ref_m[0][0] = orig[2];
      ref_m[0][2] = nv;
      checkArray("a032", 4);

      // heap_size above DEPTH is clamped; child 32 must not alias slot 0.
      $display("[TB] heap size clamp");
      writeSlot(0, mk(20, 'h500));
      writeSlot(15, mk(1, 'h515));
      writeSlot(31, mk(9, 'h531));
      applyStimulus(15, 100, 31, 1, 4, 0, 0, 0, '0);
      swapRef(15, 31);
      checkArray("clamp", DEPTH);

      // Writes past the array are dropped, reads past it return zero.
      writeSlot(33, '1);
      checkArray("oob_wr", DEPTH);
      rd_idx = 16'd40;
      #1;
      checkOutput("oob_rd", rd_data, 0);

      // Reset during the second SWAP of a three-level sift.
      $display("[TB] reset mid-sift");
      for (int i = 0; i < 7; i++) writeSlot(i, mk(i + 1, 'h600 + i));
      @(negedge clk);
      start     = 1'b1;
      start_idx = 16'd0;
      heap_size = 16'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_done", done, 0);
      checkOutput("mid_rst_final", final_idx, 0);
      checkOutput("mid_rst_swap", swap_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      swapRef(0, 2);
      checkArray("a041", 8);
      applyStimulus(2, 7, 6, 1, 4, 0, 0, 0, '0);
      swapRef(2, 6);
      checkArray("a041b", 8);

      // 4-ary min-heap with a tie between children 2 and 3.
      $display("[TB] min-heap 4-ary tie");
      sel = 1'b1;
      loadKeys(5, 8, 3, 2, 2, 6, 'h700);
      applyStimulus(0, 5, 2, 1, 4, 0, 0, 0, '0);
      ref_m[1][0] = orig[2]; ref_m[1][2] = orig[0];
      checkArray("b038", 8);

      // Randomised heaps on both instances against the reference sift.
      $display("[TB] random heaps");
      for (int t = 0; t < 12; t++) begin
         sel = t[0];
         fillAll(1);
         hs   = $urandom_range(0, 40);
         sidx = (t < 9) ? $urandom_range(0, 2) : $urandom_range(0, 40);
         modelSift(sidx, hs, fin, sw);
         applyStimulus(sidx, hs, fin, sw, 2 * sw + 2, t[1], 0, 0, '0);
         checkArray($sformatf("rnd%0d", t), DEPTH);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/path_sift_down_engine.md
PATH_SIFT_DOWN_ENGINE -- requirements
Module: path_sift_down_engine

Interface
REQ-001 SHALL have parameter KEY_W, default 32, comparison key width (MSBs of each entry).
REQ-002 SHALL have parameter ENTRY_W, default 65, full entry width (key plus payload); ENTRY_W > KEY_W.
REQ-003 SHALL have parameter DEPTH, default 1000, number of heap slots held internally.
REQ-004 SHALL have parameter IDX_W, default 16, index/size width; 2^IDX_W > ARITY*DEPTH.
REQ-005 SHALL have parameter ARITY, default 2, children per node, legal values 2 or 4.
REQ-006 SHALL have parameter MIN_HEAP, default 0; 0 = max-heap, 1 = min-heap.
REQ-007 SHALL have port system1000  input  1  clock, all state on rising edge.
REQ-008 SHALL have port system1000_rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port wr_en  input  1  write one heap slot, honoured only when busy=0.
REQ-010 SHALL have port wr_idx  input  IDX_W  slot written.
REQ-011 SHALL have port wr_data  input  ENTRY_W  entry written.
REQ-012 SHALL have port rd_idx  input  IDX_W  slot read, combinational.
REQ-013 SHALL have port rd_data  output  ENTRY_W  entry at rd_idx; 0 if rd_idx >= DEPTH.
REQ-014 SHALL have port start  input  1  begin sift-down, honoured only when busy=0.
REQ-015 SHALL have port start_idx  input  IDX_W  node to sift.
REQ-016 SHALL have port heap_size  input  IDX_W  live entry count, sampled with start.
REQ-017 SHALL have port busy  output  1  high from the edge after accepted start until the edge after done.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port final_idx  output  IDX_W  resting index of sifted entry, valid while done=1 and held until next start.
REQ-020 SHALL have port swap_cnt  output  IDX_W  swaps performed by the last operation, held until next start.

Function
REQ-021 SHALL use states IDLE, CMP, SWAP, FIN.
REQ-022 On start with busy=0, SHALL latch cur=start_idx and size=min(heap_size, DEPTH), clear swap_cnt, and enter CMP.
REQ-023 In CMP, SHALL form candidate children c = ARITY*cur+1 .. ARITY*cur+ARITY and exclude any c >= size.
REQ-024 In CMP, SHALL select best child: largest key (MIN_HEAP=0) or smallest key (MIN_HEAP=1), unsigned compare; ties among children go to the lowest index.
REQ-025 SHALL go CMP->SWAP only if best child key is strictly better than parent key; equal keys SHALL NOT swap.
REQ-026 SHALL go CMP->FIN if no candidate exists, no child is strictly better, or cur >= size.
REQ-027 In SWAP, SHALL exchange full entries at cur and best child in one edge, set cur=child, increment swap_cnt, and return to CMP.
REQ-028 In FIN, SHALL drive done=1 and final_idx=cur, then go to IDLE.
REQ-029 For k swaps, done SHALL be high in the cycle after the (2k+2)-th edge counted from the edge that accepted start.
REQ-030 start while busy=1, and wr_en while busy=1, SHALL be ignored with no state change.
REQ-031 wr_en with wr_idx >= DEPTH SHALL be ignored.
REQ-032 Simultaneous wr_en and start at busy=0 SHALL perform the write first; the sift sees the written value.
REQ-033 heap_size=0 or start_idx >= heap_size SHALL complete with swap_cnt=0 and final_idx=start_idx.
REQ-034 Payload bits (below KEY_W) SHALL move with their key and never affect ordering.

Reset
REQ-035 Reset SHALL force IDLE, busy=0, done=0, final_idx=0, swap_cnt=0 asynchronously, including mid-operation.
REQ-036 Heap storage SHALL NOT be reset; a sift interrupted by reset SHALL leave every completed swap in place.

Verification
REQ-037 Max-heap, ARITY=2, load keys [1,9,5,7,3], start_idx=0, size=5 -> 2 swaps, array [9,7,5,1,3], final_idx=3, done 6 edges after start.
REQ-038 Min-heap, ARITY=4, keys [8,3,2,2,6], start_idx=0, size=5 -> 1 swap with index 2 (tie, lowest index), final_idx=2, swap_cnt=1.
REQ-039 Keys [4,4,4], start_idx=0 -> no swap, final_idx=0, swap_cnt=0, done 2 edges after start.
REQ-040 Start with start_idx=7, heap_size=5 -> done after 2 edges, swap_cnt=0, final_idx=7, storage unchanged.
REQ-041 Assert reset in SWAP state of a 3-level sift -> busy=0 immediately, earlier swaps kept, next start runs normally.
REQ-042 start and wr_en pulsed while busy=1 -> no effect on array, final_idx or done timing.
